tick_generator: RTL

- Parametrised multi-channel timebase, the successor to the power-of-two clock divider.
- Produces an exact-rate single-cycle strobe and a near-50% square wave per channel from the 50 MHz board clock.
- Each channel's divisor is an arbitrary integer, not a counter bit tap.
- Adds run/pause and a synchronous clear, so the scoreboard can hold and restart timing (game clock, shot clock, display mux) without resetting the device.

---
 rtl/tick_generator_pkg.sv | 40 ++++
 rtl/tick_generator_channel.sv | 96 +++++++++
 rtl/tick_generator.sv | 57 +++++
 3 files changed

// File: rtl/tick_generator_pkg.sv
// -----------------------------------------------------------------------------
// tick_generator_pkg
// Shared constants and types for the multi-channel timebase.
//   - Board clock rate and the default divisors for the scoreboard timebases
//     (120 Hz display mux, 60 Hz, 1 Hz game clock, 0.5 Hz slow blink).
//   - Per-channel next-state action type used by tick_channel.
//   - Divisor legality helper used at elaboration time.
// -----------------------------------------------------------------------------
package tick_generator_pkg;

    localparam int DEF_CNT_W = 27;
    localparam int CLK_HZ    = 50000000;

    // 50 MHz / 120 = 416666.67 and 50 MHz / 60 = 833333.33, rounded to nearest.
    localparam logic [DEF_CNT_W-1:0] DIV_120HZ = 27'd416667;
    localparam logic [DEF_CNT_W-1:0] DIV_60HZ  = 27'd833333;
    localparam logic [DEF_CNT_W-1:0] DIV_1HZ   = DEF_CNT_W'(CLK_HZ);
    localparam logic [DEF_CNT_W-1:0] DIV_2S    = DEF_CNT_W'(2 * CLK_HZ);

    // What a channel does on the coming clock edge.
    typedef enum logic [2:0] {
        ACT_CLEAR = 3'd0,   // synchronous restart to count 0
        ACT_HOLD  = 3'd1,   // paused: count and wave hold
        ACT_WRAP  = 3'd2,   // last count: reload 0, strobe tick, drop wave
        ACT_RISE  = 3'd3,   // end of low phase: increment, raise wave
        ACT_COUNT = 3'd4    // plain increment
    } ch_act_t;

    // A divisor is usable when it is at least 2 and representable in w bits.
    function automatic bit div_legal(input logic [63:0] d, input int w);
        bit fits;
        if (w >= 64) begin
            fits = 1'b1;
        end else begin
            fits = (d < (64'd1 << w));
        end
        return (d >= 64'd2) && fits;
    endfunction

endpackage

// File: rtl/tick_generator_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One timebase channel: a 0..DIV-1 counter with a registered one-cycle tick at
// the wrap and a registered square wave (low for DIV/2 counts, high for the
// rest, so odd divisors give the extra cycle to the high phase).
// Ports:
//   clock_in  in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   enable    in   1 = count, 0 = hold count and wave (tick forced low)
//   clear     in   synchronous restart to count 0, overrides enable
//   tick      out  one-cycle strobe every DIV enabled cycles
//   wave      out  square wave
// -----------------------------------------------------------------------------
module tick_channel
    import tick_generator_pkg::*;
#(
    parameter int              CNT_W = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DIV  = CNT_W'(2)
) (
    input  logic clock_in,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick,
    output logic wave
);

    // Wrap is an explicit compare against DIV-1; the wave rises when the
    // count leaves H-1, i.e. after H enabled cycles of low phase.
    localparam logic [CNT_W-1:0] LP_LAST = DIV - CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_RISE = (DIV >> 1) - CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_wave;
    ch_act_t          w_act;

    // Decode the action for the next edge; clear outranks enable.
    always_comb begin
        w_act = ACT_HOLD;
        if (clear) begin
            w_act = ACT_CLEAR;
        end else if (!enable) begin
            w_act = ACT_HOLD;
        end else if (r_cnt == LP_LAST) begin
            w_act = ACT_WRAP;
        end else if (r_cnt == LP_RISE) begin
            w_act = ACT_RISE;
        end else begin
            w_act = ACT_COUNT;
        end
    end

    // Counter, tick and wave state.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_tick <= 1'b0;
            r_wave <= 1'b0;
        end else begin
            case (w_act)
                ACT_CLEAR: begin
                    r_cnt  <= {CNT_W{1'b0}};
                    r_tick <= 1'b0;
                    r_wave <= 1'b0;
                end
                ACT_HOLD: begin
                    r_tick <= 1'b0;
                end
                ACT_WRAP: begin
                    r_cnt  <= {CNT_W{1'b0}};
                    r_tick <= 1'b1;
                    r_wave <= 1'b0;
                end
                ACT_RISE: begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_tick <= 1'b0;
                    r_wave <= 1'b1;
                end
                ACT_COUNT: begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_tick <= 1'b0;
                end
                default: begin
                    r_cnt  <= {CNT_W{1'b0}};
                    r_tick <= 1'b0;
                    r_wave <= 1'b0;
                end
            endcase
        end
    end

    assign tick = r_tick;
    assign wave = r_wave;

endmodule

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
// Multi-channel timebase: NUM_CH independent tick_channel instances sharing
// enable and clear, each with its own integer divisor from DIV_LIST
// (channel i = DIV_LIST[i*CNT_W +: CNT_W]). All outputs are flop outputs.
// Ports:
//   clock_in  in   system clock (50 MHz board clock)
//   reset     in   asynchronous active-high reset
//   enable    in   run (1) / pause (0)
//   clear     in   synchronous restart of every channel
//   tick      out  [NUM_CH] per-channel one-cycle strobe
//   wave      out  [NUM_CH] per-channel square wave
// -----------------------------------------------------------------------------
module tick_generator
    import tick_generator_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_LIST = {DIV_2S, DIV_1HZ, DIV_60HZ, DIV_120HZ}
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] wave
);

    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_wave;

    if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
        $error("tick_generator: NUM_CH must be 1..8");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (!div_legal(64'(DIV_LIST[i*CNT_W +: CNT_W]), CNT_W)) begin : g_bad_div
            $error("tick_generator: channel divisor must be >= 2 and < 2**CNT_W");
        end

        tick_channel #(
            .CNT_W (CNT_W),
            .DIV   (DIV_LIST[i*CNT_W +: CNT_W])
        ) u_ch (
            .clock_in (clock_in),
            .reset    (reset),
            .enable   (enable),
            .clear    (clear),
            .tick     (w_tick[i]),
            .wave     (w_wave[i])
        );
    end

    assign tick = w_tick;
    assign wave = w_wave;

endmodule
